// File: rtl/wave_demux_capture.sv
// Serial-to-parallel capture for the 8:1 select-tree waveform generator.
// Rebuilds LSB-first 8-bit frames, checks them against EXPECT, and keeps frame and error status.
module wave_demux_capture #(
    parameter logic [7:0]  EXPECT = 8'b10111000,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             din,
    output logic [2:0]       sel,
    output logic [7:0]       data,
    output logic             valid,
    output logic             match,
    output logic             err,
    output logic             locked,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {StIdle, StCapture} state_e;

    state_e     state;
    logic [6:0] shadow;
    logic [7:0] word;

    // The incoming bit completes the word when it lands in slot 7.
    assign word   = {din, shadow};
    assign locked = (state == StCapture);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            sel       <= 3'd0;
            shadow    <= 7'd0;
            data      <= 8'd0;
            valid     <= 1'b0;
            match     <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (en && sync) begin
                        shadow[0] <= din;
                        sel       <= 3'd1;
                        state     <= StCapture;
                    end
                end
                StCapture: begin
                    if (en) begin
                        if (sync) begin
                            // Sync at slot 0 is an aligned restart; anywhere else it aborts.
                            shadow[0] <= din;
                            sel       <= 3'd1;
                            if (sel != 3'd0) begin
                                err <= 1'b1;
                            end
                        end else if (sel == 3'd7) begin
                            data      <= word;
                            valid     <= 1'b1;
                            match     <= (word == EXPECT);
                            frame_cnt <= frame_cnt + 1'b1;
                            sel       <= 3'd0;
                            if (word != EXPECT) begin
                                err <= 1'b1;
                            end
                        end else begin
                            shadow[sel] <= din;
                            sel         <= sel + 3'd1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_demux_capture.sv
// Self-checking bench for wave_demux_capture: a vector table for the first frame,
// a scoreboard of expected frames checked on every valid pulse, and directed corner sequences.
module tb_wave_demux_capture;

    localparam logic [7:0] EXPECT = 8'hB8;

    logic       clk = 1'b0;
    logic       reset, en, sync, din;
    logic [2:0] sel;
    logic [7:0] data;
    logic       valid, match, err, locked;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    wave_demux_capture #(
        .EXPECT (EXPECT),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .din       (din),
        .sel       (sel),
        .data      (data),
        .valid     (valid),
        .match     (match),
        .err       (err),
        .locked    (locked),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [7:0] data;
        logic       match;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        logic       en;
        logic       sync;
        logic       din;
        logic [2:0] sel;
        logic       locked;
        logic       valid;
    } vec_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;
    int         vcnt  = 0;
    logic [7:0] mcnt  = 8'd0;
    logic       merr  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic s, input logic d);
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        exp_t x;
        mcnt    = mcnt + 8'd1;
        merr    = merr | (w != EXPECT);
        x.data  = w;
        x.match = (w == EXPECT);
        x.err   = merr;
        x.cnt   = mcnt;
        sbq.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        sbq.delete();
        mcnt = 8'd0;
        merr = 1'b0;
    endtask

    // Sends one full frame; gap inserts an en=0 cycle before every bit.
    task automatic send_frame(input logic [7:0] w, input logic use_sync, input logic gap);
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                step(1'b0, 1'b0, ~w[i]);
                check("gap_sel", 32'(sel), 32'(i));
                check("gap_valid", 32'(valid), 32'd0);
            end
            if (i == 7) push(w);
            step(1'b1, use_sync && (i == 0), w[i]);
            check("frame_sel", 32'(sel), 32'((i + 1) % 8));
        end
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest expected frame.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                vcnt++;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got data=%0h with no frame pending", data);
                end else begin
                    x = sbq.pop_front();
                    check("sb_data", 32'(data), 32'(x.data));
                    check("sb_match", 32'(match), 32'(x.match));
                    check("sb_err", 32'(err), 32'(x.err));
                    check("sb_cnt", 32'(frame_cnt), 32'(x.cnt));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[10];
        int   v0;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};  // no sync in IDLE: ignored
        tbl[1] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};  // sync without en: ignored
        tbl[2] = '{1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1};

        en = 1'b0; sync = 1'b0; din = 1'b0; reset = 1'b0;
        do_reset();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);

        // First frame from the vector table.
        for (int i = 0; i < 10; i++) begin
            if (i == 9) push(EXPECT);
            step(tbl[i].en, tbl[i].sync, tbl[i].din);
            check("tbl_sel", 32'(sel), 32'(tbl[i].sel));
            check("tbl_locked", 32'(locked), 32'(tbl[i].locked));
            check("tbl_valid", 32'(valid), 32'(tbl[i].valid));
        end
        check("f1_data", 32'(data), 32'hB8);
        check("f1_match", 32'(match), 32'd1);

        // Back-to-back frames without sync.
        v0 = vcnt;
        for (int f = 0; f < 3; f++) send_frame(EXPECT, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("b2b_cnt", 32'(frame_cnt), 32'd4);
        check("b2b_valids", 32'(vcnt - v0), 32'd3);

        // Mismatch sets sticky err; a later good frame keeps it.
        send_frame(8'h00, 1'b0, 1'b0);
        send_frame(EXPECT, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("sticky_err", 32'(err), 32'd1);
        check("sticky_match", 32'(match), 32'd1);

        // en alternating across a frame.
        v0 = vcnt;
        send_frame(EXPECT, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("gap_valids", 32'(vcnt - v0), 32'd1);
        check("gap_data", 32'(data), 32'hB8);

        // Reset in mid-frame at sel=4.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, EXPECT[i]);
        check("pre_rst_sel", 32'(sel), 32'd4);
        do_reset();
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1);
            check("nosync_sel", 32'(sel), 32'd0);
            check("nosync_locked", 32'(locked), 32'd0);
        end

        // Abort with sync at sel=5, then finish a frame from that sync bit.
        for (int i = 0; i < 5; i++) step(1'b1, i == 0, EXPECT[i]);
        check("abort_pre_sel", 32'(sel), 32'd5);
        merr = 1'b1;
        step(1'b1, 1'b1, EXPECT[0]);
        check("abort_err", 32'(err), 32'd1);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_sel", 32'(sel), 32'd1);
        check("abort_cnt", 32'(frame_cnt), 32'd0);
        for (int i = 1; i < 8; i++) begin
            if (i == 7) push(EXPECT);
            step(1'b1, 1'b0, EXPECT[i]);
        end
        step(1'b0, 1'b0, 1'b0);
        check("abort_done_cnt", 32'(frame_cnt), 32'd1);

        // Aligned resync at sel=0 keeps err clear; sync at sel=7 aborts.
        do_reset();
        send_frame(EXPECT, 1'b1, 1'b0);
        send_frame(EXPECT, 1'b1, 1'b0);
        check("resync_err", 32'(err), 32'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, EXPECT[i]);
        check("s7_pre_sel", 32'(sel), 32'd7);
        step(1'b1, 1'b1, 1'b1);
        check("s7_valid", 32'(valid), 32'd0);
        check("s7_err", 32'(err), 32'd1);
        check("s7_sel", 32'(sel), 32'd1);
        check("s7_cnt", 32'(frame_cnt), 32'd2);

        // Frame counter wraps after 256 frames.
        do_reset();
        send_frame(EXPECT, 1'b1, 1'b0);
        for (int f = 1; f < 256; f++) send_frame(EXPECT, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("wrap_cnt", 32'(frame_cnt), 32'd0);
        check("wrap_err", 32'(err), 32'd0);

        step(1'b0, 1'b0, 1'b0);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
